fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_if.sv | 28 ++
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: redirect/stall inputs, instruction memory port,
// and the output slot feeding the IF/ID register.
interface fetch_if #(
    parameter int unsigned ADDRESS_LEN = 32
);
    logic                   freeze;
    logic                   branch_taken;
    logic [ADDRESS_LEN-1:0] branch_addr;
    logic                   mem_req;
    logic [ADDRESS_LEN-1:0] mem_addr;
    logic                   mem_ack;
    logic [ADDRESS_LEN-1:0] mem_rdata;
    logic                   if_valid;
    logic [ADDRESS_LEN-1:0] if_instr;
    logic [ADDRESS_LEN-1:0] if_pc;

    // Fetch unit side.
    modport master (
        input  freeze, branch_taken, branch_addr, mem_ack, mem_rdata,
        output mem_req, mem_addr, if_valid, if_instr, if_pc
    );

    // Pipeline / memory side.
    modport slave (
        output freeze, branch_taken, branch_addr, mem_ack, mem_rdata,
        input  mem_req, mem_addr, if_valid, if_instr, if_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction memory from the pc,
// presents fetched words in a single output slot, and uses a one-entry skid
// buffer to absorb a word that returns while the slot is frozen.
module fetch_unit #(
    parameter int unsigned             ADDRESS_LEN = 32,
    parameter logic [ADDRESS_LEN-1:0]  RESET_PC    = '0
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);
    localparam logic [ADDRESS_LEN-1:0] PC_STEP = ADDRESS_LEN'(4);

    typedef enum logic {
        ST_REQ,
        ST_HOLD
    } state_t;

    state_t                 state, state_next;
    logic [ADDRESS_LEN-1:0] pc, pc_next;
    logic [ADDRESS_LEN-1:0] pc_inc;

    logic                   slot_valid, slot_valid_next;
    logic [ADDRESS_LEN-1:0] slot_instr, slot_instr_next;
    logic [ADDRESS_LEN-1:0] slot_pc, slot_pc_next;

    logic                   skid_valid, skid_valid_next;
    logic [ADDRESS_LEN-1:0] skid_instr, skid_instr_next;
    logic [ADDRESS_LEN-1:0] skid_pc, skid_pc_next;

    logic                   slot_free;

    // Wraps modulo 2^ADDRESS_LEN by construction.
    assign pc_inc    = pc + PC_STEP;
    // The slot may be overwritten when empty or when ID is consuming it.
    assign slot_free = !slot_valid || !bus.freeze;

    assign bus.mem_req  = (state == ST_REQ);
    assign bus.mem_addr = pc;
    assign bus.if_valid = slot_valid;
    assign bus.if_instr = slot_instr;
    assign bus.if_pc    = slot_pc;

    // State register, pc, output slot and skid buffer with async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_REQ;
            pc         <= RESET_PC;
            slot_valid <= 1'b0;
            slot_instr <= '0;
            slot_pc    <= '0;
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            slot_valid <= slot_valid_next;
            slot_instr <= slot_instr_next;
            slot_pc    <= slot_pc_next;
            skid_valid <= skid_valid_next;
            skid_instr <= skid_instr_next;
            skid_pc    <= skid_pc_next;
        end
    end

    // Next-state logic: branch redirect first, then fetch/stall handling.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        slot_valid_next = slot_valid;
        slot_instr_next = slot_instr;
        slot_pc_next    = slot_pc;
        skid_valid_next = skid_valid;
        skid_instr_next = skid_instr;
        skid_pc_next    = skid_pc;

        if (bus.branch_taken) begin
            // Redirect kills both buffered words and any word acked this cycle.
            pc_next         = bus.branch_addr;
            slot_valid_next = 1'b0;
            skid_valid_next = 1'b0;
            state_next      = ST_REQ;
        end else begin
            unique case (state)
                ST_REQ: begin
                    if (bus.mem_ack) begin
                        pc_next = pc_inc;
                        if (slot_free) begin
                            slot_valid_next = 1'b1;
                            slot_instr_next = bus.mem_rdata;
                            slot_pc_next    = pc_inc;
                        end else begin
                            skid_valid_next = 1'b1;
                            skid_instr_next = bus.mem_rdata;
                            skid_pc_next    = pc_inc;
                            state_next      = ST_HOLD;
                        end
                    end else if (!bus.freeze) begin
                        // Slot consumed with nothing to replace it: bubble.
                        slot_valid_next = 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!bus.freeze) begin
                        // Drain skid into the slot; fetching resumes next cycle.
                        slot_valid_next = skid_valid;
                        slot_instr_next = skid_instr;
                        slot_pc_next    = skid_pc;
                        skid_valid_next = 1'b0;
                        state_next      = ST_REQ;
                    end
                end
                default: state_next = ST_REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// freeze/ack/branch traffic scored against an in-order instruction stream model.
module tb_fetch_unit;
    localparam int unsigned AW  = 32;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;

    int unsigned n_tests;
    int unsigned n_fail;
    logic [31:0] exp_addr;   // address of the next instruction ID should receive

    fetch_if #(.ADDRESS_LEN(AW)) bus ();

    fetch_unit #(.ADDRESS_LEN(AW), .RESET_PC(RPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Memory returns the word at the requested address only when acking.
    assign bus.mem_rdata = bus.mem_ack ? word(bus.mem_addr) : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: apply inputs, score a consumed slot before the edge,
    // then check freeze/branch effects just after the edge.
    task automatic cycle(input logic f, input logic b, input logic [31:0] ba, input logic a);
        logic        pv;
        logic [31:0] pi;
        logic [31:0] pp;
        bus.freeze       = f;
        bus.branch_taken = b;
        bus.branch_addr  = ba;
        bus.mem_ack      = a;
        @(negedge clk);
        pv = bus.if_valid;
        pi = bus.if_instr;
        pp = bus.if_pc;
        if (!b && !f && pv) begin
            check("stream_pc", pp, exp_addr + 32'd4);
            check("stream_instr", pi, word(exp_addr));
            exp_addr = exp_addr + 32'd4;
        end
        if (b) exp_addr = ba;
        @(posedge clk);
        #1;
        if (b) begin
            check("branch_valid", 32'(bus.if_valid), 32'd0);
            check("branch_skid", 32'(dut.skid_valid), 32'd0);
            check("branch_addr", bus.mem_addr, ba);
            check("branch_req", 32'(bus.mem_req), 32'd1);
        end else if (f && pv) begin
            check("freeze_valid", 32'(bus.if_valid), 32'd1);
            check("freeze_instr", bus.if_instr, pi);
            check("freeze_pc", bus.if_pc, pp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst              = 1'b1;
        bus.freeze       = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_addr  = '0;
        bus.mem_ack      = 1'b0;
        #2;
        check("rst_valid", 32'(bus.if_valid), 32'd0);
        check("rst_instr", bus.if_instr, 32'd0);
        check("rst_pc", bus.if_pc, 32'd0);
        check("rst_addr", bus.mem_addr, RPC);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        exp_addr = RPC;
        check("rel_req", 32'(bus.mem_req), 32'd1);
        check("rel_addr", bus.mem_addr, RPC);

        // Streaming from reset: if_pc 4, 8 with words at 0, 4.
        for (int k = 1; k <= 2; k++) begin
            cycle(1'b0, 1'b0, 32'd0, 1'b1);
            check("seq_valid", 32'(bus.if_valid), 32'd1);
            check("seq_pc", bus.if_pc, 32'(4 * k));
            check("seq_instr", bus.if_instr, word(32'(4 * (k - 1))));
        end

        // Freeze for three cycles with the slot at if_pc=8.
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b0, 32'd0, 1'b1);
            check("hold_req", 32'(bus.mem_req), 32'd0);
            check("hold_slot_pc", bus.if_pc, 32'd8);
            check("hold_skid_pc", dut.skid_pc, 32'd12);
            check("hold_skid_instr", dut.skid_instr, word(32'd8));
        end
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check("unfreeze_pc1", bus.if_pc, 32'd12);
        check("unfreeze_instr1", bus.if_instr, word(32'd8));
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check("unfreeze_pc2", bus.if_pc, 32'd16);

        // Two cycles without ack: bubbles, address stays put.
        for (int k = 0; k < 2; k++) begin
            cycle(1'b0, 1'b0, 32'd0, 1'b0);
            check("noack_valid", 32'(bus.if_valid), 32'd0);
            check("noack_addr", bus.mem_addr, 32'd16);
        end
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check("ack_resume_pc", bus.if_pc, 32'd20);
        check("ack_resume_instr", bus.if_instr, word(32'd16));

        // Enter HOLD, then branch under freeze and ack.
        cycle(1'b1, 1'b0, 32'd0, 1'b1);
        check("pre_branch_skid", 32'(dut.skid_valid), 32'd1);
        cycle(1'b1, 1'b1, 32'h0000_0100, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check("post_branch_valid", 32'(bus.if_valid), 32'd1);
        check("post_branch_pc", bus.if_pc, 32'h0000_0104);

        // Branch to the top word: next pc wraps to zero.
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check("wrap_pc", bus.if_pc, 32'h0000_0000);
        check("wrap_instr", bus.if_instr, word(32'hFFFF_FFFC));
        check("wrap_addr", bus.mem_addr, 32'h0000_0000);

        // Asynchronous reset while in HOLD with a valid skid entry.
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        cycle(1'b1, 1'b0, 32'd0, 1'b1);
        check("arst_pre_skid", 32'(dut.skid_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(bus.if_valid), 32'd0);
        check("arst_instr", bus.if_instr, 32'd0);
        check("arst_pc", bus.if_pc, 32'd0);
        check("arst_skid", 32'(dut.skid_valid), 32'd0);
        check("arst_addr", bus.mem_addr, RPC);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        exp_addr = RPC;
        check("arst_rel_req", 32'(bus.mem_req), 32'd1);
        check("arst_rel_addr", bus.mem_addr, RPC);

        // Random traffic against the stream model.
        for (int k = 0; k < 400; k++) begin
            logic        f;
            logic        b;
            logic        a;
            logic [31:0] ba;
            f = ($urandom_range(0, 2) == 0);
            a = ($urandom_range(0, 2) != 0);
            b = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0)
                ba = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
            else
                ba = $urandom() & 32'hFFFF_FFFC;
            cycle(f, b, ba, a);
        end

        // Full-rate drain: one valid instruction every cycle.
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b0, 32'd0, 1'b1);
            check("drain_valid", 32'(bus.if_valid), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
